// File: rtl/regfile_wr_arbiter.sv
// Shares the register-file write port between ALU writeback, load writeback and the
// two-beat PC-save sequence. The save always wins; ALU/memory contention is round-robin.
module regfile_wr_arbiter #(
  parameter int unsigned ADDR_W    = 4,
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned PC_HI_REG = 10,
  parameter int unsigned PC_LO_REG = 9
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alu_valid,
  input  logic [ADDR_W-1:0] alu_addr,
  input  logic [DATA_W-1:0] alu_data,
  output logic              alu_ready,
  input  logic              mem_valid,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_data,
  output logic              mem_ready,
  input  logic              pc_save_req,
  input  logic [31:0]       pc_save_val,
  output logic              pc_save_busy,
  output logic              pc_save_done,
  output logic              we,
  output logic [ADDR_W-1:0] waddr,
  output logic [DATA_W-1:0] wdata,
  output logic              stall
);

  localparam logic [ADDR_W-1:0] PcHiAddr = ADDR_W'(PC_HI_REG);
  localparam logic [ADDR_W-1:0] PcLoAddr = ADDR_W'(PC_LO_REG);

  typedef enum logic [1:0] {StIdle, StSaveHi, StSaveLo} state_e;

  state_e            r_state;
  state_e            w_state_d;
  logic              r_rr_ptr;
  logic [31:0]       r_pc;
  logic              r_we;
  logic [ADDR_W-1:0] r_waddr;
  logic [DATA_W-1:0] r_wdata;
  logic              r_done;

  logic w_alu_grant;
  logic w_mem_grant;
  logic w_contended;
  logic w_save_start;

  always_comb begin
    w_state_d    = r_state;
    w_alu_grant  = 1'b0;
    w_mem_grant  = 1'b0;
    w_contended  = 1'b0;
    w_save_start = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (pc_save_req) begin
          w_state_d    = StSaveHi;
          w_save_start = 1'b1;
        end else if (alu_valid && mem_valid) begin
          w_contended = 1'b1;
          w_alu_grant = ~r_rr_ptr;
          w_mem_grant = r_rr_ptr;
        end else begin
          w_alu_grant = alu_valid;
          w_mem_grant = mem_valid;
        end
      end
      StSaveHi: w_state_d = StSaveLo;
      StSaveLo: w_state_d = StIdle;
      default:  w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= StIdle;
      r_rr_ptr <= 1'b0;
      r_pc     <= '0;
      r_we     <= 1'b0;
      r_waddr  <= '0;
      r_wdata  <= '0;
      r_done   <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_we    <= 1'b0;
      r_done  <= 1'b0;
      if (w_save_start) r_pc <= pc_save_val;
      // The pointer moves to the loser only when both writers were competing.
      if (w_contended) r_rr_ptr <= ~r_rr_ptr;
      if (r_state == StSaveHi) begin
        r_we    <= 1'b1;
        r_waddr <= PcHiAddr;
        r_wdata <= DATA_W'(r_pc[31:16]);
      end else if (r_state == StSaveLo) begin
        r_we    <= 1'b1;
        r_waddr <= PcLoAddr;
        r_wdata <= DATA_W'(r_pc[15:0]);
        r_done  <= 1'b1;
      end else if (w_alu_grant) begin
        r_we    <= 1'b1;
        r_waddr <= alu_addr;
        r_wdata <= alu_data;
      end else if (w_mem_grant) begin
        r_we    <= 1'b1;
        r_waddr <= mem_addr;
        r_wdata <= mem_data;
      end
    end
  end

  assign alu_ready    = w_alu_grant;
  assign mem_ready    = w_mem_grant;
  assign stall        = (alu_valid & ~w_alu_grant) | (mem_valid & ~w_mem_grant);
  assign pc_save_busy = (r_state != StIdle);
  assign pc_save_done = r_done;
  assign we           = r_we;
  assign waddr        = r_waddr;
  assign wdata        = r_wdata;

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Bench for regfile_wr_arbiter: directed vector table, then randomized traffic against
// a transaction-level model of the write-port sharing rules.
module tb_regfile_wr_arbiter;

  logic        clk;
  logic        rst;
  logic        alu_valid;
  logic [3:0]  alu_addr;
  logic [15:0] alu_data;
  logic        alu_ready;
  logic        mem_valid;
  logic [3:0]  mem_addr;
  logic [15:0] mem_data;
  logic        mem_ready;
  logic        pc_save_req;
  logic [31:0] pc_save_val;
  logic        pc_save_busy;
  logic        pc_save_done;
  logic        we;
  logic [3:0]  waddr;
  logic [15:0] wdata;
  logic        stall;

  regfile_wr_arbiter #(
    .ADDR_W(4),
    .DATA_W(16),
    .PC_HI_REG(10),
    .PC_LO_REG(9)
  ) dut (
    .clk(clk),
    .rst(rst),
    .alu_valid(alu_valid),
    .alu_addr(alu_addr),
    .alu_data(alu_data),
    .alu_ready(alu_ready),
    .mem_valid(mem_valid),
    .mem_addr(mem_addr),
    .mem_data(mem_data),
    .mem_ready(mem_ready),
    .pc_save_req(pc_save_req),
    .pc_save_val(pc_save_val),
    .pc_save_busy(pc_save_busy),
    .pc_save_done(pc_save_done),
    .we(we),
    .waddr(waddr),
    .wdata(wdata),
    .stall(stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Registered outputs in a row describe the port during that row's cycle.
  typedef struct {
    logic        rst;
    logic        av;
    logic [3:0]  aa;
    logic [15:0] ad;
    logic        mv;
    logic [3:0]  ma;
    logic [15:0] md;
    logic        pr;
    logic [31:0] pv;
    logic        e_ar;
    logic        e_mr;
    logic        e_st;
    logic        e_busy;
    logic        e_we;
    logic [3:0]  e_wa;
    logic [15:0] e_wd;
    logic        e_done;
  } vec_t;

  vec_t vecs[$];

  task automatic drive(input logic r, input logic av, input logic [3:0] aa,
                       input logic [15:0] ad, input logic mv, input logic [3:0] ma,
                       input logic [15:0] md, input logic pr, input logic [31:0] pv);
    rst = r; alu_valid = av; alu_addr = aa; alu_data = ad;
    mem_valid = mv; mem_addr = ma; mem_data = md;
    pc_save_req = pr; pc_save_val = pv;
  endtask

  task automatic check_all(input string tag, input logic ar, input logic mr, input logic st,
                           input logic busy, input logic e_we, input logic [3:0] wa,
                           input logic [15:0] wd, input logic done);
    chk({tag, ".alu_ready"}, 32'(alu_ready), 32'(ar));
    chk({tag, ".mem_ready"}, 32'(mem_ready), 32'(mr));
    chk({tag, ".stall"}, 32'(stall), 32'(st));
    chk({tag, ".busy"}, 32'(pc_save_busy), 32'(busy));
    chk({tag, ".we"}, 32'(we), 32'(e_we));
    chk({tag, ".waddr"}, 32'(waddr), 32'(wa));
    chk({tag, ".wdata"}, 32'(wdata), 32'(wd));
    chk({tag, ".done"}, 32'(pc_save_done), 32'(done));
  endtask

  // Reference model: save_left counts save beats still owed; mem_turn says who wins a tie.
  int          m_save_left;
  logic [31:0] m_pc;
  bit          m_mem_turn;
  logic        m_we;
  logic [3:0]  m_wa;
  logic [15:0] m_wd;
  logic        m_done;
  logic        m_ar;
  logic        m_mr;

  task automatic model_reset();
    m_save_left = 0; m_pc = '0; m_mem_turn = 0;
    m_we = 0; m_wa = '0; m_wd = '0; m_done = 0;
  endtask

  task automatic model_comb();
    m_ar = 0;
    m_mr = 0;
    if (m_save_left == 0 && !pc_save_req) begin
      m_ar = alu_valid && (!mem_valid || !m_mem_turn);
      m_mr = mem_valid && (!alu_valid || m_mem_turn);
    end
  endtask

  task automatic model_step();
    if (rst) begin
      model_reset();
      return;
    end
    m_we = 0;
    m_done = 0;
    if (m_save_left == 2) begin
      m_we = 1; m_wa = 4'd10; m_wd = m_pc[31:16]; m_save_left = 1;
    end else if (m_save_left == 1) begin
      m_we = 1; m_wa = 4'd9; m_wd = m_pc[15:0]; m_done = 1; m_save_left = 0;
    end else if (pc_save_req) begin
      m_pc = pc_save_val; m_save_left = 2;
    end else begin
      if (alu_valid && mem_valid) m_mem_turn = !m_mem_turn;
      if (m_ar) begin
        m_we = 1; m_wa = alu_addr; m_wd = alu_data;
      end else if (m_mr) begin
        m_we = 1; m_wa = mem_addr; m_wd = mem_data;
      end
    end
  endtask

  task automatic add(input logic r, input logic av, input logic [3:0] aa, input logic [15:0] ad,
                     input logic mv, input logic [3:0] ma, input logic [15:0] md,
                     input logic pr, input logic [31:0] pv,
                     input logic ar, input logic mr, input logic st, input logic busy,
                     input logic e_we, input logic [3:0] wa, input logic [15:0] wd,
                     input logic done);
    vec_t v;
    v.rst = r; v.av = av; v.aa = aa; v.ad = ad; v.mv = mv; v.ma = ma; v.md = md;
    v.pr = pr; v.pv = pv; v.e_ar = ar; v.e_mr = mr; v.e_st = st; v.e_busy = busy;
    v.e_we = e_we; v.e_wa = wa; v.e_wd = wd; v.e_done = done;
    vecs.push_back(v);
  endtask

  initial begin
    bit a_pend;
    bit m_pend;

    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;

    //   rst av aa ad       mv ma md       pr pv            ar mr st bz we wa  wd       dn
    add(0, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 32'h0,       0, 0, 0, 0, 0, 0,  16'h0000, 0);
    add(0, 1, 3, 16'h1234, 0, 0, 16'h0000, 0, 32'h0,       1, 0, 0, 0, 0, 0,  16'h0000, 0);
    add(0, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 32'h0,       0, 0, 0, 0, 1, 3,  16'h1234, 0);
    add(0, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 32'h0,       0, 0, 0, 0, 0, 3,  16'h1234, 0);
    add(0, 1, 1, 16'hAAAA, 1, 2, 16'h5555, 0, 32'h0,       1, 0, 1, 0, 0, 3,  16'h1234, 0);
    add(0, 0, 1, 16'hAAAA, 1, 2, 16'h5555, 0, 32'h0,       0, 1, 0, 0, 1, 1,  16'hAAAA, 0);
    add(0, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 32'h0,       0, 0, 0, 0, 1, 2,  16'h5555, 0);
    add(0, 1, 4, 16'h0101, 1, 5, 16'h0202, 0, 32'h0,       0, 1, 1, 0, 0, 2,  16'h5555, 0);
    add(0, 1, 4, 16'h0101, 0, 5, 16'h0202, 0, 32'h0,       1, 0, 0, 0, 1, 5,  16'h0202, 0);
    add(0, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 32'h0,       0, 0, 0, 0, 1, 4,  16'h0101, 0);
    add(0, 0, 0, 16'h0000, 0, 0, 16'h0000, 1, 32'hDEADBEEF, 0, 0, 0, 0, 0, 4, 16'h0101, 0);
    add(0, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 32'h0,       0, 0, 0, 1, 0, 4,  16'h0101, 0);
    add(0, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 32'h0,       0, 0, 0, 1, 1, 10, 16'hDEAD, 0);
    add(0, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 32'h0,       0, 0, 0, 0, 1, 9,  16'hBEEF, 1);
    add(0, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 32'h0,       0, 0, 0, 0, 0, 9,  16'hBEEF, 0);
    add(0, 1, 7, 16'h7777, 0, 0, 16'h0000, 1, 32'h12345678, 0, 0, 1, 0, 0, 9, 16'hBEEF, 0);
    add(0, 1, 7, 16'h7777, 0, 0, 16'h0000, 0, 32'h0,       0, 0, 1, 1, 0, 9,  16'hBEEF, 0);
    add(0, 1, 7, 16'h7777, 0, 0, 16'h0000, 0, 32'h0,       0, 0, 1, 1, 1, 10, 16'h1234, 0);
    add(0, 1, 7, 16'h7777, 0, 0, 16'h0000, 0, 32'h0,       1, 0, 0, 0, 1, 9,  16'h5678, 1);
    add(0, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 32'h0,       0, 0, 0, 0, 1, 7,  16'h7777, 0);
    add(0, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 32'h0,       0, 0, 0, 0, 0, 7,  16'h7777, 0);
    add(0, 0, 0, 16'h0000, 0, 0, 16'h0000, 1, 32'hCAFEF00D, 0, 0, 0, 0, 0, 7, 16'h7777, 0);
    add(1, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 32'h0,       0, 0, 0, 1, 0, 7,  16'h7777, 0);
    for (int i = 0; i < 10; i++)
      add(0, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 32'h0,     0, 0, 0, 0, 0, 0,  16'h0000, 0);

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].av, vecs[i].aa, vecs[i].ad, vecs[i].mv, vecs[i].ma,
            vecs[i].md, vecs[i].pr, vecs[i].pv);
      #4;
      check_all($sformatf("vec%0d", i), vecs[i].e_ar, vecs[i].e_mr, vecs[i].e_st,
                vecs[i].e_busy, vecs[i].e_we, vecs[i].e_wa, vecs[i].e_wd, vecs[i].e_done);
      @(posedge clk);
      #1;
    end

    // Randomized traffic: requesters hold their request until the model grants it.
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    model_reset();
    a_pend = 0;
    m_pend = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      rst = ($urandom_range(199) == 0);
      if (!a_pend && $urandom_range(2) == 0) begin
        a_pend = 1;
        alu_addr = 4'($urandom);
        alu_data = 16'($urandom);
      end
      if (!m_pend && $urandom_range(2) == 0) begin
        m_pend = 1;
        mem_addr = 4'($urandom);
        mem_data = 16'($urandom);
      end
      alu_valid   = a_pend;
      mem_valid   = m_pend;
      pc_save_req = ($urandom_range(9) == 0);
      pc_save_val = $urandom;
      model_comb();
      #4;
      check_all($sformatf("rnd%0d", cyc), m_ar, m_mr,
                (alu_valid && !m_ar) || (mem_valid && !m_mr), m_save_left != 0,
                m_we, m_wa, m_wd, m_done);
      model_step();
      if (m_ar) a_pend = 0;
      if (m_mr) m_pend = 0;
      @(posedge clk);
      #1;
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
